// File: rtl/leaf_stream_bank.sv
// Purpose: merges NUM_PORTS valid/ready input streams into one output stream via per-channel FIFOs and an arbiter.
// Latency: 2 edges from input acceptance to val_out with an idle bank; sustains 1 word/cycle at the output.
// Backpressure: ready_upward[i] is derived only from the registered FIFO count (never from ready_downward or val_in).
//
// Ports:
//   clk            - sole clock, rising edge
//   resetn         - synchronous active-low reset
//   din            - channel payloads, channel i at [i*DATA_W +: DATA_W]
//   val_in         - per-channel valid
//   ready_upward   - per-channel ready (FIFO not full, forced low during reset)
//   dout/dout_port - merged payload and its source channel index
//   val_out        - merged valid
//   ready_downward - consumer ready
//   fifo_empty     - per-channel FIFO empty flag
module leaf_stream_bank #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int PORT_BITS = 3,
    parameter int ARB_MODE  = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_PORTS*DATA_W-1:0]   din,
    input  logic [NUM_PORTS-1:0]          val_in,
    output logic [NUM_PORTS-1:0]          ready_upward,
    output logic [DATA_W-1:0]             dout,
    output logic [PORT_BITS-1:0]          dout_port,
    output logic                          val_out,
    input  logic                          ready_downward,
    output logic [NUM_PORTS-1:0]          fifo_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Per-channel storage and bookkeeping
    logic [DATA_W-1:0]    mem_q    [NUM_PORTS][DEPTH];
    logic [CNT_W-1:0]     cnt_q    [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d    [NUM_PORTS];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_PORTS];

    // Output register and arbiter state
    logic [DATA_W-1:0]    dout_q;
    logic [PORT_BITS-1:0] dout_port_q;
    logic                 val_out_q;
    logic [PORT_BITS-1:0] last_grant_q;

    logic [NUM_PORTS-1:0] fifo_nonempty;
    logic [NUM_PORTS-1:0] push;
    logic                 load_en;
    logic                 pop;
    logic                 grant_vld;
    logic [PORT_BITS-1:0] grant_idx;
    logic [DATA_W-1:0]    grant_dat;

    // Flags come straight from the registered counts; resetn gates ready so
    // nothing is accepted while the bank is held in reset.
    always_comb begin
        ready_upward  = '0;
        fifo_empty    = '0;
        fifo_nonempty = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            ready_upward[i]  = resetn && (cnt_q[i] != DEPTH_C);
            fifo_empty[i]    = (cnt_q[i] == '0);
            fifo_nonempty[i] = (cnt_q[i] != '0);
        end
    end

    assign push = val_in & ready_upward;

    // Output register may load when empty or when its word is being consumed.
    assign load_en = !val_out_q || ready_downward;
    assign pop     = load_en && grant_vld;

    // Arbiter: first non-empty channel in search order. Round-robin starts
    // one past the last granted channel; fixed priority starts at channel 0.
    always_comb begin
        int cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_dat = '0;
        cand      = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            if (ARB_MODE == 1) begin
                cand = off;
            end else begin
                cand = (int'(last_grant_q) + 1 + off) % NUM_PORTS;
            end
            if (!grant_vld && fifo_nonempty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = PORT_BITS'(cand);
                grant_dat = mem_q[cand][rd_ptr_q[cand]];
            end
        end
    end

    // Per-channel pointer/count next state. A write and a pop on the same
    // edge leave the count unchanged while both pointers advance.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            logic rd;
            rd          = pop && (grant_idx == PORT_BITS'(i));
            cnt_d[i]    = cnt_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (push[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
            end
            if (rd) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
            end
            if (push[i] && !rd) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (!push[i] && rd) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            val_out_q    <= 1'b0;
            dout_q       <= '0;
            dout_port_q  <= '0;
            // Channel 0 is searched first after reset
            last_grant_q <= PORT_BITS'(NUM_PORTS - 1);
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (load_en) begin
                val_out_q <= grant_vld;
            end
            if (pop) begin
                dout_q       <= grant_dat;
                dout_port_q  <= grant_idx;
                last_grant_q <= grant_idx;
            end
        end
    end

    // Payload storage needs no reset: counts gate every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= din[i*DATA_W +: DATA_W];
            end
        end
    end

    assign dout      = dout_q;
    assign dout_port = dout_port_q;
    assign val_out   = val_out_q;

endmodule

// File: tb/tb_leaf_stream_bank.sv
// Purpose: checks leaf_stream_bank in both arbitration modes against a queue-based reference model.
// Latency: model and DUT are compared 1 time unit after every rising edge.
// Backpressure: ready_downward is driven by the stimulus, both directed and random.
module tb_leaf_stream_bank;
    localparam int NP    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PB    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic [NP*DW-1:0]  din;
    logic [NP-1:0]     val_in;
    logic              ready_downward;

    logic [NP-1:0] ru0, fe0, ru1, fe1;
    logic [DW-1:0] do0, do1;
    logic [PB-1:0] dp0, dp1;
    logic          vo0, vo1;

    leaf_stream_bank #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .PORT_BITS(PB), .ARB_MODE(0)) dut_rr (
        .clk(clk), .resetn(resetn), .din(din), .val_in(val_in), .ready_upward(ru0),
        .dout(do0), .dout_port(dp0), .val_out(vo0), .ready_downward(ready_downward), .fifo_empty(fe0)
    );

    leaf_stream_bank #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .PORT_BITS(PB), .ARB_MODE(1)) dut_fp (
        .clk(clk), .resetn(resetn), .din(din), .val_in(val_in), .ready_upward(ru1),
        .dout(do1), .dout_port(dp1), .val_out(vo1), .ready_downward(ready_downward), .fifo_empty(fe1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per channel per instance (index m*NP+c),
    // plus the contents of the single output slot.
    logic [DW-1:0] mq [2*NP][$];
    bit            mv [2];
    logic [DW-1:0] md [2];
    int            mp [2];
    int            ml [2];
    logic [DW-1:0] w  [6];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One rising edge of the ideal bank m (0 round-robin, 1 fixed priority)
    task automatic model_edge(input int m);
        logic [NP-1:0] acc;
        bit found;
        int ch;
        int c2;
        if (!resetn) begin
            for (int c = 0; c < NP; c++) mq[m*NP+c].delete();
            mv[m] = 1'b0;
            md[m] = '0;
            mp[m] = 0;
            ml[m] = NP - 1;
            return;
        end
        for (int c = 0; c < NP; c++) acc[c] = val_in[c] && (mq[m*NP+c].size() < DEPTH);
        if (!mv[m] || ready_downward) begin
            found = 1'b0;
            ch    = 0;
            for (int k = 0; k < NP; k++) begin
                c2 = (m == 0) ? (ml[m] + 1 + k) % NP : k;
                if (!found && mq[m*NP+c2].size() > 0) begin
                    found = 1'b1;
                    ch    = c2;
                end
            end
            if (found) begin
                md[m] = mq[m*NP+ch].pop_front();
                mp[m] = ch;
                ml[m] = ch;
                mv[m] = 1'b1;
            end else begin
                mv[m] = 1'b0;
            end
        end
        for (int c = 0; c < NP; c++) if (acc[c]) mq[m*NP+c].push_back(din[c*DW +: DW]);
    endtask

    task automatic compare(input int m, input logic [NP-1:0] ru, input logic [NP-1:0] fe,
                           input logic vo, input logic [DW-1:0] dq, input logic [PB-1:0] dp);
        logic [NP-1:0] er;
        logic [NP-1:0] ee;
        for (int c = 0; c < NP; c++) begin
            er[c] = resetn && (mq[m*NP+c].size() != DEPTH);
            ee[c] = (mq[m*NP+c].size() == 0);
        end
        check($sformatf("ready_upward[inst%0d]", m), 32'(ru), 32'(er));
        check($sformatf("fifo_empty[inst%0d]", m), 32'(fe), 32'(ee));
        check($sformatf("val_out[inst%0d]", m), 32'(vo), 32'(mv[m]));
        if (mv[m]) begin
            check($sformatf("dout[inst%0d]", m), dq, md[m]);
            check($sformatf("dout_port[inst%0d]", m), 32'(dp), 32'(mp[m]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare(0, ru0, fe0, vo0, do0, dp0);
        compare(1, ru1, fe1, vo1, do1, dp1);
    endtask

    task automatic rand_din();
        for (int c = 0; c < NP; c++) din[c*DW +: DW] = $urandom();
    endtask

    initial begin
        resetn = 1'b0;
        din = '0;
        val_in = '0;
        ready_downward = 1'b0;

        // Reset state
        step();
        step();
        check("rst_dout", do0, 32'h0);
        check("rst_dout_port", 32'(dp0), 32'h0);
        check("rst_val_out", 32'(vo0), 32'h0);
        check("rst_ready_low", 32'(ru0), 32'h0);
        check("rst_fifo_empty", 32'(fe0), 32'h1f);

        // Single word, two-edge latency, one cycle only
        resetn = 1'b1;
        ready_downward = 1'b1;
        val_in = 5'b00001;
        din = '0;
        din[31:0] = 32'hDEADBEEF;
        step();
        check("single_lat_k", 32'(vo0), 32'h0);
        val_in = '0;
        step();
        check("single_val", 32'(vo0), 32'h1);
        check("single_dout", do0, 32'hDEADBEEF);
        check("single_port", 32'(dp0), 32'h0);
        step();
        check("single_once", 32'(vo0), 32'h0);

        // Round-robin fairness from a fresh reset, every channel preloaded
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        ready_downward = 1'b0;
        val_in = 5'h1f;
        for (int k = 0; k < 4; k++) begin
            rand_din();
            step();
        end
        val_in = '0;
        ready_downward = 1'b1;
        for (int j = 0; j < 20; j++) begin
            check("fair_val", 32'(vo0), 32'h1);
            check("fair_port", 32'(dp0), 32'(j % NP));
            step();
        end
        check("fair_drained", 32'(vo0), 32'h0);

        // Fixed priority: channel 0 always wins while it is fed
        val_in = 5'b01001;
        for (int k = 0; k < 10; k++) begin
            rand_din();
            step();
            if (k >= 1) begin
                check("prio_val", 32'(vo1), 32'h1);
                check("prio_port", 32'(dp1), 32'h0);
            end
        end
        val_in = '0;
        step();
        check("prio_last0", 32'(dp1), 32'h0);
        step();
        check("prio_then3", 32'(dp1), 32'h3);
        for (int k = 0; k < 14; k++) step();

        // Backpressure on channel 2
        ready_downward = 1'b0;
        val_in = 5'b00100;
        for (int k = 0; k < 5; k++) begin
            w[k] = $urandom();
            din[2*DW +: DW] = w[k];
            step();
            if (k == 3) check("bp_ready_at4", 32'(ru0[2]), 32'h1);
        end
        w[5] = $urandom();
        din[2*DW +: DW] = w[5];
        for (int k = 0; k < 3; k++) begin
            check("bp_ready_full", 32'(ru0[2]), 32'h0);
            check("bp_hold_val", 32'(vo0), 32'h1);
            check("bp_hold_dout", do0, w[0]);
            step();
        end
        val_in = '0;
        ready_downward = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_order", do0, w[k]);
            step();
        end
        check("bp_drained", 32'(vo0), 32'h0);

        // Simultaneous write and pop on channel 1 at count 3
        ready_downward = 1'b0;
        val_in = 5'b00010;
        for (int k = 0; k < 4; k++) begin
            rand_din();
            step();
        end
        check("simul_pre_ready", 32'(ru0[1]), 32'h1);
        ready_downward = 1'b1;
        rand_din();
        step();
        check("simul_ready", 32'(ru0[1]), 32'h1);
        check("simul_nonempty", 32'(fe0[1]), 32'h0);
        ready_downward = 1'b0;
        rand_din();
        step();
        check("simul_count3_then_full", 32'(ru0[1]), 32'h0);
        val_in = '0;
        ready_downward = 1'b1;
        for (int k = 0; k < 8; k++) step();

        // Reset mid-stream discards everything
        ready_downward = 1'b0;
        val_in = 5'b00111;
        for (int k = 0; k < 2; k++) begin
            rand_din();
            step();
        end
        check("midrst_pre_val", 32'(vo0), 32'h1);
        check("midrst_pre_empty", 32'(fe0[2:0]), 32'h0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        val_in = '0;
        #1;
        check("midrst_val", 32'(vo0), 32'h0);
        check("midrst_empty", 32'(fe0), 32'h1f);
        check("midrst_ready", 32'(ru0), 32'h1f);
        check("midrst_ready_fp", 32'(ru1), 32'h1f);
        ready_downward = 1'b1;
        step();
        check("midrst_no_output", 32'(vo0), 32'h0);

        // Random traffic with occasional resets, then drain
        for (int k = 0; k < 400; k++) begin
            resetn = ($urandom_range(0, 99) != 0);
            val_in = NP'($urandom());
            rand_din();
            ready_downward = ($urandom_range(0, 3) != 0);
            step();
        end
        resetn = 1'b1;
        val_in = '0;
        ready_downward = 1'b1;
        for (int k = 0; k < 30; k++) step();
        check("final_drained", 32'(vo0), 32'h0);
        check("final_empty", 32'(fe1), 32'h1f);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
